cnt_snapshot: RTL and testbench

Downstream consumer of the pipelined counter family (`rtl_cnt`, `rtl_cnt_bk` and variants). It takes the counter's registered `cnt`/`cout` outputs and extends the count with an M-bit overflow counter. On request it captures a coherent {extension, count} snapshot into a small FIFO, which a consumer drains through a valid/ready handshake. It gives software-visible timestamps wider than N without widening the carry-propagation core.

---
 rtl/cnt_pkg.sv | 21 ++
 rtl/snap_fifo.sv | 59 +++++
 rtl/cnt_snapshot.sv | 99 +++++++++
 tb/tb_cnt_snapshot.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_pkg.sv
// Shared definitions for the snapshot extender.
// Optional feature: CNT_SNAPSHOT_TAG_EN prepends a 4-bit capture sequence tag to each snapshot.
package cnt_pkg;

  localparam int unsigned TAG_W = 4;
  localparam int unsigned DEF_N = 17;
  localparam int unsigned DEF_M = 8;

  // Snapshot word width for a given counter width n and extension width m
  function automatic int unsigned snap_w(input int unsigned n, input int unsigned m);
`ifdef CNT_SNAPSHOT_TAG_EN
    return n + m + TAG_W;
`else
    return n + m;
`endif
  endfunction

  // Snapshot word at the default counter/extension widths
  typedef logic [snap_w(DEF_N, DEF_M)-1:0] snap_t;

endpackage

// File: rtl/snap_fifo.sv
// Pointer-plus-count snapshot FIFO with synchronous active-high reset.
// Head data reads zero while empty so the output is never X.
module snap_fifo
  import cnt_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  // Pop only with a valid head; push into a full FIFO only when the head leaves this cycle
  always_comb begin
    valid   = (count != '0);
    full    = (count == (AW+1)'(DEPTH));
    do_pop  = pop & valid;
    do_push = push & (~full | do_pop);
    dout    = valid ? mem[rd_ptr] : '0;
    level   = count;
  end

  // Storage array, no reset needed since reads are gated by valid
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/cnt_snapshot.sv
// Extends an upstream N-bit counter with an M-bit overflow count and queues coherent
// {ext, cnt} snapshots on request. Optional feature: CNT_SNAPSHOT_TAG_EN adds a 4-bit
// capture sequence tag in the MSBs so consumers can spot dropped captures.
module cnt_snapshot
  import cnt_pkg::*;
#(
  parameter int unsigned N     = 17,
  parameter int unsigned M     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N-1:0]             cnt_i,
  input  logic                     cout_i,
  input  logic                     cap_i,
  input  logic                     ovr_clr_i,
  output logic                     snap_valid_o,
  input  logic                     snap_ready_i,
  output logic [snap_w(N, M)-1:0]  snap_data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     ovr_o,
  output logic                     ext_wrap_o
);

  localparam int unsigned W = snap_w(N, M);

  logic [M-1:0] ext;
  logic [M-1:0] ext_eff;
  logic         full;
  logic         pop;
  logic         drop;
  logic         push;
  logic [W-1:0] snap_word;

  // cout_i marks the cycle cnt_i already shows the wrapped value, so fold it in for capture
  always_comb begin
    ext_eff = ext + M'(cout_i);
    pop     = snap_valid_o & snap_ready_i;
    drop    = cap_i & full & ~pop;
    push    = cap_i & ~drop;
  end

`ifdef CNT_SNAPSHOT_TAG_EN
  logic [TAG_W-1:0] tag;

  // Sequence number advances on every request, accepted or dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      tag <= '0;
    end else if (cap_i) begin
      tag <= tag + TAG_W'(1);
    end
  end

  assign snap_word = {tag, ext_eff, cnt_i};
`else
  assign snap_word = {ext_eff, cnt_i};
`endif

  // Extension counter and its sticky wrap flag
  always_ff @(posedge clk) begin
    if (reset) begin
      ext        <= '0;
      ext_wrap_o <= 1'b0;
    end else if (cout_i) begin
      ext <= ext + M'(1);
      if (ext == '1) begin
        ext_wrap_o <= 1'b1;
      end
    end
  end

  // Sticky overrun: a same-cycle drop beats the clear
  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_o <= 1'b0;
    end else if (drop) begin
      ovr_o <= 1'b1;
    end else if (ovr_clr_i) begin
      ovr_o <= 1'b0;
    end
  end

  snap_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (snap_word),
    .pop   (snap_ready_i),
    .dout  (snap_data_o),
    .valid (snap_valid_o),
    .full  (full),
    .level (level_o)
  );

endmodule

// File: tb/tb_cnt_snapshot.sv
// Bench for cnt_snapshot at N=4, M=8, DEPTH=4; honours CNT_SNAPSHOT_TAG_EN when defined.
module tb_cnt_snapshot;

  localparam int unsigned N     = 4;
  localparam int unsigned M     = 8;
  localparam int unsigned DEPTH = 4;
`ifdef CNT_SNAPSHOT_TAG_EN
  localparam int unsigned W = 16;
`else
  localparam int unsigned W = 12;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] cnt_i = '0;
  logic         cout_i = 1'b0;
  logic         cap_i = 1'b0;
  logic         ovr_clr_i = 1'b0;
  logic         snap_ready_i = 1'b0;
  logic         snap_valid;
  logic [W-1:0] snap_data;
  logic [2:0]   level;
  logic         ovr;
  logic         ext_wrap;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  cnt_snapshot #(
    .N     (N),
    .M     (M),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cnt_i        (cnt_i),
    .cout_i       (cout_i),
    .cap_i        (cap_i),
    .ovr_clr_i    (ovr_clr_i),
    .snap_valid_o (snap_valid),
    .snap_ready_i (snap_ready_i),
    .snap_data_o  (snap_data),
    .level_o      (level),
    .ovr_o        (ovr),
    .ext_wrap_o   (ext_wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Snapshot word from plain field values; the tag part falls off when W=12
  function automatic logic [W-1:0] mk(input int tag, input int ext, input int cnt);
    return W'((tag % 16) * 4096 + (ext % 256) * 16 + (cnt % 16));
  endfunction

  // Reference: queue of pending snapshots, total cout pulses, flags, request count
  logic [W-1:0] q[$];
  int pulses = 0;
  bit m_ovr = 1'b0;
  int m_tag = 0;

  always @(posedge clk) begin : model
    bit popped;
    bit dropped;
    popped  = 1'b0;
    dropped = 1'b0;
    if (reset) begin
      q.delete();
      pulses = 0;
      m_ovr  = 1'b0;
      m_tag  = 0;
    end else begin
      popped = (q.size() > 0) && snap_ready_i;
      if (popped) void'(q.pop_front());
      if (cap_i) begin
        if (q.size() < DEPTH) q.push_back(mk(m_tag, pulses + int'(cout_i), int'(cnt_i)));
        else dropped = 1'b1;
        m_tag++;
      end
      if (dropped) m_ovr = 1'b1;
      else if (ovr_clr_i) m_ovr = 1'b0;
      if (cout_i) pulses++;
    end
  end

  // Every-cycle comparison against the reference
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", 32'(snap_valid), 32'(q.size() != 0));
      chk("data", 32'(snap_data), (q.size() != 0) ? 32'(q[0]) : 32'd0);
      chk("level", 32'(level), 32'(q.size()));
      chk("ovr", 32'(ovr), 32'(m_ovr));
      chk("ext_wrap", 32'(ext_wrap), 32'(pulses >= 256));
    end
  end

  task automatic drv(input int c, input bit co, input bit cp, input bit rd, input bit cl);
    cnt_i        = N'(c);
    cout_i       = co;
    cap_i        = cp;
    snap_ready_i = rd;
    ovr_clr_i    = cl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rd_pct;
    reset = 1'b1;
    drv(0, 0, 0, 0, 0);
    drv(0, 1, 1, 0, 0);
    reset  = 1'b0;
    chk_en = 1'b1;
    chk("rst_valid", 32'(snap_valid), 32'd0);
    chk("rst_data", 32'(snap_data), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_flags", {30'd0, ovr, ext_wrap}, 32'd0);

    // Capture in the cycle the upstream counter wraps
    drv(14, 0, 0, 0, 0);
    drv(15, 0, 0, 0, 0);
    drv(0, 1, 1, 0, 0);
    chk("wrap_coh", 32'(snap_data[11:0]), 32'h010);
    chk("wrap_coh_valid", 32'(snap_valid), 32'd1);
    drv(1, 0, 0, 1, 0);
    drv(2, 0, 0, 0, 0);
    drv(3, 0, 1, 0, 0);
    chk("later_cap", 32'(snap_data[11:0]), 32'h013);
    drv(4, 0, 0, 1, 0);
    chk("drained", 32'(level), 32'd0);

    // Backpressure: five captures into a depth-4 FIFO, then drop racing a clear
    for (int i = 0; i < 5; i++) drv(5 + i, 0, 1, 0, 0);
    chk("bp_level", 32'(level), 32'd4);
    chk("bp_ovr", 32'(ovr), 32'd1);
    drv(10, 0, 1, 0, 1);
    chk("drop_beats_clr", 32'(ovr), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("bp_order", 32'(snap_data), 32'(mk(2 + i, 1, 5 + i)));
      drv(11, 0, 0, 1, 0);
    end
    chk("bp_empty", 32'(snap_valid), 32'd0);
    drv(0, 0, 0, 0, 1);
    chk("ovr_clr", 32'(ovr), 32'd0);

    // Full FIFO with push and pop in the same cycle
    for (int i = 0; i < 4; i++) drv(10 + i, 0, 1, 0, 0);
    chk("full_level", 32'(level), 32'd4);
    drv(14, 0, 1, 1, 0);
    chk("pp_level", 32'(level), 32'd4);
    chk("pp_ovr", 32'(ovr), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("pp_order", 32'(snap_data), 32'(mk(9 + i, 1, 11 + i)));
      drv(15, 0, 0, 1, 0);
    end

    // Reset with queued data; capture and cout in the reset cycle are ignored
    for (int i = 0; i < 3; i++) drv(1 + i, 0, 1, 0, 0);
    chk("pre_rst_level", 32'(level), 32'd3);
    reset = 1'b1;
    drv(5, 1, 1, 1, 0);
    reset = 1'b0;
    chk("mid_rst_valid", 32'(snap_valid), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_flags", {30'd0, ovr, ext_wrap}, 32'd0);
    drv(4, 0, 1, 0, 0);
    chk("post_rst_cap", 32'(snap_data), 32'(mk(0, 0, 4)));
    drv(4, 0, 0, 1, 0);

    // Extension wrap after 256 carry pulses
    for (int i = 0; i < 255; i++) drv(i, 1, 0, 0, 0);
    chk("no_wrap_255", 32'(ext_wrap), 32'd0);
    drv(0, 1, 0, 0, 0);
    chk("wrap_256", 32'(ext_wrap), 32'd1);
    drv(5, 0, 1, 0, 0);
    chk("ext_after_wrap", 32'(snap_data), 32'(mk(1, 0, 5)));
    chk("ext_after_wrap_field", 32'(snap_data[11:4]), 32'd0);
    drv(5, 0, 0, 1, 0);

    // Six captures into an empty FIFO with no pops; tags expose the two drops
    reset = 1'b1;
    drv(0, 0, 0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) drv(i, 0, 1, 0, 0);
    chk("tag_level", 32'(level), 32'd4);
    chk("tag_ovr", 32'(ovr), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("tag_order", 32'(snap_data), 32'(mk(i, 0, i)));
      drv(6, 0, 0, 1, 0);
    end
    drv(6, 0, 1, 0, 0);
    chk("tag_next", 32'(snap_data), 32'(mk(6, 0, 6)));
`ifdef CNT_SNAPSHOT_TAG_EN
    chk("tag_field", 32'(snap_data[15:12]), 32'd6);
`endif
    drv(6, 0, 0, 1, 0);

    // Randomised traffic with varying consumer readiness
    rd_pct = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 0) rd_pct = int'($urandom_range(10, 95));
      reset = ($urandom_range(0, 199) == 0);
      drv(int'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
          int'($urandom_range(0, 99)) < rd_pct, $urandom_range(0, 9) == 0);
    end
    reset = 1'b0;
    drv(0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
